// File: rtl/bk_serial_accumulator_pkg.sv
// bk_pkg: definitions shared by the nibble-serial accumulator slice.
//   NIB_W   : width of one streamed nibble
//   state_t : accumulator control states
//   idx_w() : index width needed to address n nibbles (never below 1)
package bk_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_PROP,
    ST_OUT
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/bk_serial_accumulator_brent_kung_cin.sv
// brent_kung_cin: 4-bit Brent-Kung prefix adder with carry-in.
//   a, b : 4-bit addends
//   cin  : carry in
//   out  : {carry_out, sum[3:0]}
module brent_kung_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] out
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g10, p10, g32, p32, g20, p20, g30, p30;
  logic [4:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    // Up-sweep: pair groups, then the full span.
    g10 = g[1] | (p[1] & g[0]);
    p10 = p[1] & p[0];
    g32 = g[3] | (p[3] & g[2]);
    p32 = p[3] & p[2];
    g30 = g32 | (p32 & g10);
    p30 = p32 & p10;
    // Down-sweep fills the remaining odd prefix.
    g20 = g[2] | (p[2] & g10);
    p20 = p[2] & p10;

    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g10 | (p10 & cin);
    c[3] = g20 | (p20 & cin);
    c[4] = g30 | (p30 & cin);

    out = {c[4], p ^ c[3:0]};
  end

endmodule

// File: rtl/bk_serial_accumulator.sv
// bk_serial_accumulator: nibble-serial accumulator built around one 4-bit
// brent_kung_cin adder. Operands stream in LSB nibble first and are added
// into a NIBBLES-wide accumulator; the updated sum then streams out.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : zero accumulator and overflow (taken only in ACC at idx 0)
//   in_valid/in_ready/in_nib/in_last    : operand nibble stream
//   res_valid/res_ready/res_nib/res_last : result nibble stream (registered)
//   ovf        : sticky carry out of the top nibble
module bk_serial_accumulator
  import bk_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NIB_W-1:0] in_nib,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [NIB_W-1:0] res_nib,
  output logic             res_last,
  output logic             ovf
);

  localparam int unsigned IW = idx_w(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t           state, state_d;
  logic [NIB_W-1:0] acc [NIBBLES];
  logic [IW-1:0]    idx;
  logic [IW-1:0]    oidx;
  logic             carry;

  logic             clr_now;
  logic             fire;
  logic             at_last;
  logic             out_last;
  logic [NIB_W-1:0] add_b;
  logic [NIB_W:0]   add_out;
  logic             cout;

  brent_kung_cin u_add (
    .a   (acc[idx]),
    .b   (add_b),
    .cin (carry),
    .out (add_out)
  );

  assign cout = add_out[NIB_W];

  always_comb begin
    at_last  = (idx == LAST_IDX);
    out_last = (oidx == LAST_IDX);
    clr_now  = (state == ST_ACC) && clr && (idx == '0);
    in_ready = (state == ST_ACC) && !clr_now;
    fire     = in_valid && in_ready;
    // Outside ACC the operand is zero-extended, so only carry is added.
    add_b    = (state == ST_ACC) ? in_nib : '0;

    state_d = state;
    unique case (state)
      ST_ACC: begin
        if (fire && (in_last || at_last)) begin
          if (at_last || !cout) state_d = ST_OUT;
          else                  state_d = ST_PROP;
        end
      end
      ST_PROP: begin
        if (at_last || !cout) state_d = ST_OUT;
      end
      ST_OUT: begin
        if (res_valid && res_ready && out_last) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_ACC;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NIBBLES; i++) acc[i] <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      oidx      <= '0;
      ovf       <= 1'b0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_nib   <= '0;
    end else begin
      unique case (state)
        ST_ACC: begin
          if (clr_now) begin
            for (int unsigned i = 0; i < NIBBLES; i++) acc[i] <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
          end else if (fire) begin
            acc[idx] <= add_out[NIB_W-1:0];
            carry    <= cout;
            idx      <= idx + 1'b1;
            oidx     <= '0;
            if (at_last) ovf <= ovf | cout;
          end
        end
        ST_PROP: begin
          acc[idx] <= add_out[NIB_W-1:0];
          carry    <= cout;
          idx      <= idx + 1'b1;
          oidx     <= '0;
          if (at_last) ovf <= ovf | cout;
        end
        ST_OUT: begin
          // The first OUT cycle only loads nibble 0 into the output register;
          // afterwards each accepted beat loads the next nibble directly so
          // res_valid stays high for back-to-back transfers.
          if (!res_valid) begin
            res_valid <= 1'b1;
            res_nib   <= acc[oidx];
            res_last  <= out_last;
          end else if (res_ready) begin
            if (out_last) begin
              res_valid <= 1'b0;
              res_last  <= 1'b0;
              idx       <= '0;
              carry     <= 1'b0;
            end else begin
              oidx     <= oidx + 1'b1;
              res_nib  <= acc[oidx + 1'b1];
              res_last <= ((oidx + 1'b1) == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bk_serial_accumulator.md
Name: bk_serial_accumulator

Overview:
- Nibble-serial accumulator that sits directly upstream of the tt_um_brent_kung pin wrapper.
- Reuses the existing 4-bit brent_kung_cin adder once per cycle to add a streamed operand into a NIBBLES-wide accumulator, least-significant nibble first, rippling the carry through a register.
- After each operand it streams the updated accumulator out nibble-serially with a valid/ready handshake.
- This fits wide additions through the 4-bit pin budget.

Parameters:
- NIBBLES, 4: accumulator width in nibbles (total width 4*NIBBLES); legal range 2..8.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  request to zero the accumulator and overflow flag.
- in_valid  input  1  operand nibble valid.
- in_ready  output  1  operand nibble accepted when in_valid&in_ready.
- in_nib  input  4  operand nibble, LSB-first.
- in_last  input  1  marks the final nibble of the operand.
- res_valid  output  1  result nibble valid.
- res_ready  input  1  downstream accepts the result nibble.
- res_nib  output  4  accumulator nibble, LSB-first.
- res_last  output  1  marks nibble NIBBLES-1 of the result.
- ovf  output  1  sticky flag: carry out of the top nibble.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: acc=0, carry=0, idx=0, state=ACC, res_valid=0, res_last=0, res_nib=0, ovf=0.
- Operand format: nibbles arrive LSB-first. Missing upper nibbles are treated as 0 (zero-extended).
- Adder: one brent_kung_cin instance. Inputs are acc[idx], operand nibble (or 0), and carry. Result nibble is written to acc[idx]; out[4] is written to carry. Add and write complete in 1 cycle.

State ACC:
- in_ready = 1 unless (clr && idx==0).
- On each beat: write acc[idx], update carry, idx++.
- Beat with in_last=1, or beat at idx==NIBBLES-1: operand ends.
  - If idx==NIBBLES-1: ovf |= adder carry-out; go to OUT.
  - Else if adder carry-out==0: go to OUT.
  - Else: go to PROP.
- At idx==NIBBLES-1, in_last is ignored; the beat always terminates the operand.
- clr is honoured only in ACC with idx==0.
  - Effect: acc<=0, ovf<=0, carry<=0.
  - clr has priority over in_valid that cycle (in_ready=0). The beat is accepted on a later cycle.
  - clr in any other state or index is ignored.

State PROP:
- in_ready=0. Each cycle adds 0 plus carry into acc[idx], then idx++.
- Leaves for OUT as soon as carry-out==0.
- At idx==NIBBLES-1, carry-out sets ovf before leaving for OUT.
- Worst case is NIBBLES-1 cycles.

State OUT:
- in_ready=0. Output idx restarts at 0.
- res_valid=1; res_nib=acc[oidx]; res_last=(oidx==NIBBLES-1).
- On res_valid&res_ready: oidx++.
- On the last accepted beat: idx<=0, carry<=0, res_valid<=0, go to ACC.
- res_nib and res_last are held stable while res_valid&&!res_ready.
- Outputs res_nib, res_last and res_valid are registered. The first result beat appears the cycle after entry to OUT.

Other rules:
- Carry never wraps into nibble 0. Overflow is recorded only in ovf, which stays set until clr or rst.
- Reset mid-operation (any state) restores all reset values immediately. No partial result is emitted.
- Interface is full-throughput in ACC: one nibble per cycle while in_valid is held.

Decomposition:
- Shared package bk_pkg:
  - NIB_W=4.
  - State enum {ST_ACC, ST_PROP, ST_OUT}.
  - Index width function clog2(NIBBLES).
- One natural sub-module: the existing brent_kung_cin adder, instantiated once.
- Everything else (control FSM, nibble index, accumulator register file) stays inline.

Test Plan (NIBBLES=4):
1. Reset, stream 4,3,2,1 (last on 1) → result beats 4,3,2,1, res_last on 4th, ovf=0, acc=0x1234.
2. From 0x1234, send single nibble 0xC with in_last → acc[0]=0, 1 PROP cycle to nibble1, carry dies, result 0x1240, ovf=0.
3. clr, stream F,F,F,F, read out, then single nibble 1 with in_last → PROP through 3 nibbles, result 0x0000, ovf=1. Next clr → ovf=0.
4. During OUT, hold res_ready low 3 cycles after the 2nd beat → res_nib/res_last stable, no beats lost, in_ready stays 0.
5. Assert rst for 1 cycle during PROP → all outputs at reset values next edge. A following operand 0x0005 yields 0x0005.
6. clr and in_valid (nibble 7) together at idx 0 → in_ready=0 that cycle, acc cleared. Nibble 7 accepted next cycle; result 0x0007 after last.
